// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: latched BCD/hex codes, scan prescaler,
// lamp test, blanking, leading-zero blanking and per-digit decimal points.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int HEX_EN   = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   D,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LE,
    input  logic                  LT_N,
    input  logic                  BI_N,
    input  logic                  LZB,
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     DIG_N
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] dLatch_q, dLatch_d;
    logic [DIGITS-1:0]   dpLatch_q, dpLatch_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   digN_q, digN_d;

    logic [3:0] curNib;
    logic       curDp;
    logic       curBlank;
    logic       leadZero;
    logic [6:0] glyphBits;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = (HEX_EN != 0) ? 7'h77 : 7'h00;
            4'hB: g = (HEX_EN != 0) ? 7'h7C : 7'h00;
            4'hC: g = (HEX_EN != 0) ? 7'h39 : 7'h00;
            4'hD: g = (HEX_EN != 0) ? 7'h5E : 7'h00;
            4'hE: g = (HEX_EN != 0) ? 7'h79 : 7'h00;
            default: g = (HEX_EN != 0) ? 7'h71 : 7'h00;
        endcase
        return g;
    endfunction

    // Outputs are computed from the pre-edge index and latch so SEG and DIG_N
    // always describe the same digit in the same cycle.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dLatch_d  = LE ? dLatch_q : D;
        dpLatch_d = LE ? dpLatch_q : DP;
        curNib    = 4'd0;
        curDp     = 1'b0;
        curBlank  = 1'b0;
        leadZero  = 1'b1;
        digN_d    = '1;
        glyphBits = 7'd0;
        seg_d     = 8'h00;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Walk from the most significant digit down so leadZero means "this
        // digit and everything above it is zero".
        for (int k = DIGITS - 1; k >= 0; k--) begin
            leadZero = leadZero & (dLatch_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                curNib    = dLatch_q[4*k +: 4];
                curDp     = dpLatch_q[k];
                curBlank  = leadZero && (k != 0);
                digN_d[k] = 1'b0;
            end
        end

        glyphBits = glyph(curNib);
        if (LZB && curBlank) begin
            glyphBits = 7'd0;
        end

        if (!LT_N) begin
            seg_d = 8'hFF;
        end else if (!BI_N) begin
            seg_d = 8'h00;
        end else begin
            seg_d = {curDp, glyphBits};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            dLatch_q  <= '0;
            dpLatch_q <= '0;
            seg_q     <= 8'h00;
            digN_q    <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dLatch_q  <= dLatch_d;
            dpLatch_q <= dpLatch_d;
            seg_q     <= seg_d;
            digN_q    <= digN_d;
        end
    end

    assign SEG   = seg_q;
    assign DIG_N = digN_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a hex-glyph and a non-hex instance
// share one set of inputs; per-digit SEG values are gathered over full frames.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 3;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] D = 16'h0;
    logic [3:0]  DP = 4'h0;
    logic        LE = 1'b0;
    logic        LT_N = 1'b1;
    logic        BI_N = 1'b1;
    logic        LZB = 1'b0;
    logic [7:0]  segHex, segNoHex;
    logic [3:0]  digHex, digNoHex;

    int compared = 0;
    int mismatched = 0;

    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(1)) dutHex (
        .CLK(CLK), .RST_N(RST_N), .D(D), .DP(DP), .LE(LE), .LT_N(LT_N),
        .BI_N(BI_N), .LZB(LZB), .SEG(segHex), .DIG_N(digHex)
    );

    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(0)) dutNoHex (
        .CLK(CLK), .RST_N(RST_N), .D(D), .DP(DP), .LE(LE), .LT_N(LT_N),
        .BI_N(BI_N), .LZB(LZB), .SEG(segNoHex), .DIG_N(digNoHex)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0]     d;
        logic [3:0]      dp;
        logic            lzb;
        logic [3:0][7:0] expHex;
        logic [3:0][7:0] expNoHex;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic lzb);
        @(negedge CLK);
        D   = d;
        DP  = dp;
        LZB = lzb;
        repeat (FRAME + 2) @(negedge CLK);
    endtask

    // Samples one full frame and files each SEG value under the digit DIG_N selects.
    task automatic captureFrame(output logic [3:0][7:0] hexSeg, output logic [3:0][7:0] noHexSeg);
        logic [3:0] seen;
        int badCnt;
        int k;
        seen     = 4'h0;
        badCnt   = 0;
        hexSeg   = '0;
        noHexSeg = '0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge CLK);
            case (digHex)
                4'hE: k = 0;
                4'hD: k = 1;
                4'hB: k = 2;
                4'h7: k = 3;
                default: k = -1;
            endcase
            if (k < 0 || digNoHex !== digHex) begin
                badCnt++;
            end else begin
                seen[k]     = 1'b1;
                hexSeg[k]   = segHex;
                noHexSeg[k] = segNoHex;
            end
        end
        checkOutput("frameDigitsSeen", {4'h0, seen}, 8'h0F);
        checkOutput("frameOneHotLow", 8'(badCnt), 8'h00);
    endtask

    task automatic checkFrame(input string name, input logic [3:0][7:0] expH, input logic [3:0][7:0] expN);
        logic [3:0][7:0] gotH, gotN;
        captureFrame(gotH, gotN);
        for (int k = 0; k < DIGITS; k++) begin
            checkOutput($sformatf("%s_hex_d%0d", name, k), gotH[k], expH[k]);
            checkOutput($sformatf("%s_nohex_d%0d", name, k), gotN[k], expN[k]);
        end
    endtask

    initial begin
        // Vector expectations listed as {digit3, digit2, digit1, digit0}.
        vecs[0] = '{16'h0094, 4'b0000, 1'b0, {8'h3F, 8'h3F, 8'h6F, 8'h66}, {8'h3F, 8'h3F, 8'h6F, 8'h66}};
        vecs[1] = '{16'h0094, 4'b0001, 1'b0, {8'h3F, 8'h3F, 8'h6F, 8'hE6}, {8'h3F, 8'h3F, 8'h6F, 8'hE6}};
        vecs[2] = '{16'h0050, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h6D, 8'h3F}, {8'h00, 8'h00, 8'h6D, 8'h3F}};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'h3F}, {8'h00, 8'h00, 8'h00, 8'h3F}};
        vecs[4] = '{16'h00FA, 4'b0000, 1'b0, {8'h3F, 8'h3F, 8'h71, 8'h77}, {8'h3F, 8'h3F, 8'h00, 8'h00}};
        vecs[5] = '{16'h1234, 4'b1010, 1'b0, {8'h86, 8'h5B, 8'hCF, 8'h66}, {8'h86, 8'h5B, 8'hCF, 8'h66}};
        vecs[6] = '{16'h5678, 4'b0000, 1'b1, {8'h6D, 8'h7D, 8'h07, 8'h7F}, {8'h6D, 8'h7D, 8'h07, 8'h7F}};
        vecs[7] = '{16'hBCDE, 4'b0000, 1'b0, {8'h7C, 8'h39, 8'h5E, 8'h79}, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[8] = '{16'h0007, 4'b0100, 1'b1, {8'h00, 8'h80, 8'h00, 8'h07}, {8'h00, 8'h80, 8'h00, 8'h07}};

        // Reset state, then the scan sequence and first glyph after release.
        repeat (3) @(negedge CLK);
        checkOutput("resetSegHex", segHex, 8'h00);
        checkOutput("resetDigHex", {4'h0, digHex}, 8'h0F);
        checkOutput("resetSegNoHex", segNoHex, 8'h00);
        RST_N = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("scanDig_cyc%0d", i), {4'h0, digHex},
                        {4'h0, ~(4'b0001 << (((i - 1) / SCAN_DIV) % DIGITS))});
            if (i == 1) checkOutput("firstSeg", segHex, 8'h3F);
        end

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].d, vecs[v].dp, vecs[v].lzb);
            checkFrame($sformatf("vec%0d", v), vecs[v].expHex, vecs[v].expNoHex);
        end

        // Latch hold: LE rises on the same edge D changes, so the new D is ignored.
        applyStimulus(16'h0094, 4'b0000, 1'b0);
        @(negedge CLK);
        LE = 1'b1;
        D  = 16'h0000;
        repeat (FRAME) @(negedge CLK);
        checkFrame("latchHold", {8'h3F, 8'h3F, 8'h6F, 8'h66}, {8'h3F, 8'h3F, 8'h6F, 8'h66});
        LE = 1'b0;
        repeat (FRAME + 2) @(negedge CLK);
        checkFrame("latchOpen", {8'h3F, 8'h3F, 8'h3F, 8'h3F}, {8'h3F, 8'h3F, 8'h3F, 8'h3F});

        // Lamp test beats blanking; blanking alone clears SEG while scan continues.
        applyStimulus(16'h1234, 4'b0000, 1'b0);
        LT_N = 1'b0;
        repeat (2) @(negedge CLK);
        checkFrame("lampTest", {4{8'hFF}}, {4{8'hFF}});
        BI_N = 1'b0;
        repeat (2) @(negedge CLK);
        checkFrame("lampOverBlank", {4{8'hFF}}, {4{8'hFF}});
        LT_N = 1'b1;
        repeat (2) @(negedge CLK);
        checkFrame("blank", {4{8'h00}}, {4{8'h00}});
        BI_N = 1'b1;

        // Asynchronous reset mid-slot clears outputs without waiting for an edge.
        applyStimulus(16'h5678, 4'b1111, 1'b0);
        @(posedge CLK);
        #2;
        checkOutput("preResetSegNonzero", {7'h0, segHex != 8'h00}, 8'h01);
        RST_N = 1'b0;
        #1;
        checkOutput("asyncResetSeg", segHex, 8'h00);
        checkOutput("asyncResetDig", {4'h0, digHex}, 8'h0F);
        checkOutput("asyncResetSegNoHex", segNoHex, 8'h00);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("postResetSeg", segHex, 8'h3F);
        checkOutput("postResetDig", {4'h0, digHex}, 8'h0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit 7-segment display driver. It generalises the single-digit HC4511 decoder (latch enable, lamp test, blanking) to DIGITS packed BCD/hex nibbles. It adds a programmable scan prescaler, per-digit decimal points, leading-zero blanking and optional hex glyphs. It sits between the counter/datapath logic and the board's common-cathode display pins; one SEG bus is time-shared across DIGITS active-low digit enables.

## Interface
- DIGITS, default 4: number of digits scanned (≥1).
- SCAN_DIV, default 1000: CLK cycles per digit slot (≥1; 1 = advance every cycle).
- HEX_EN, default 1: 1 = codes 10–15 show A,b,C,d,E,F; 0 = codes 10–15 blank segments a–g (HC4511 behaviour).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- D  in  4*DIGITS  digit codes; D[3:0] = digit 0 (least significant, rightmost).
- DP  in  DIGITS  decimal-point request per digit, 1 = lit.
- LE  in  1  latch enable: 0 = transparent (capture D/DP every cycle), 1 = hold.
- LT_N  in  1  lamp test, active low.
- BI_N  in  1  blanking, active low.
- LZB  in  1  leading-zero blanking enable, active high.
- SEG  out  8  {dp,g,f,e,d,c,b,a}, active high, registered.
- DIG_N  out  DIGITS  one-hot-low digit enable, registered.

## Operation
- Data latch: when LE=0, D and DP are captured into the latch each clock. When LE=1, the latch holds. LT_N, BI_N and LZB are not latched.
- Prescaler: counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and the digit index advances. The index wraps from DIGITS-1 to 0.
- Output priority per cycle, evaluated for the current index k:
  - LT_N=0 → SEG=0xFF.
  - Else BI_N=0 → SEG=0x00.
  - Else decode latch nibble k, with dp = latched DP[k].
- Glyphs 0–9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Glyphs 10–15 with HEX_EN=1: 77,7C,39,5E,79,71.
- Glyphs 10–15 with HEX_EN=0: segments a–g = 0; dp still honoured.
- Leading-zero blanking: with LZB=1, digit k>0 has segments a–g forced to 0 when latched nibbles DIGITS-1 down to k are all 0. Digit 0 is never blanked. dp is still honoured.
- DIG_N: bit k low and all other bits high. DIG_N keeps scanning during LT and BI; only SEG is affected.
- DIGITS=1: index stays 0 and DIG_N=0 permanently after reset.

## Timing
- Reset values (asynchronous, immediate, including mid-scan):
  - Prescaler = 0, index = 0, latch D = 0, latch DP = 0.
  - SEG = 0x00.
  - DIG_N = all ones (all digits off).
- First edge after RST_N deasserts: DIG_N = ~1 (digit 0 on); SEG = 0x3F, because the latch holds 0.
- Index k is held for exactly SCAN_DIV cycles. Full frame = DIGITS*SCAN_DIV cycles.
- SEG and DIG_N are registered together, so they change on the same edge and there is never a cycle with a mismatched digit/glyph.
- D to SEG latency: D sampled at edge n (LE=0) appears on SEG at edge n+1 if digit k is currently selected. Otherwise it appears in k's next slot.
- LE rising at edge n: the value captured at edge n-1 is kept. D at edge n is ignored.
- LT_N, BI_N and LZB changes take effect on SEG one edge after sampling. This holds mid-slot.
- Simultaneous LT_N=0 and BI_N=0: lamp test wins, SEG=0xFF.

## Test plan
- Reset/scan (DIGITS=4, SCAN_DIV=3): after reset, expect DIG_N sequence E,D,B,7 with each value held 3 cycles, wrapping back to E. During reset, expect SEG=0x00 and DIG_N=F.
- Decode (LE=0, LT_N=1, BI_N=1, D=0x0094): digit 0 slot gives SEG=0x66, digit 1 slot gives SEG=0x6F. Set DP=0b0001 → digit 0 slot gives SEG=0xE6.
- Latch: with LE=1, change D to 0x0000 → SEG keeps 0x66/0x6F. With LE=0 → digit 0 shows 0x3F from its next slot.
- Lamp test / blank: LT_N=0 → SEG=0xFF in every slot, including with BI_N=0. LT_N=1, BI_N=0 → SEG=0x00 while DIG_N keeps scanning.
- LZB: D=0x0050, LZB=1 → digits 3 and 2 show 0x00, digit 1 shows 0x6D, digit 0 shows 0x3F. D=0x0000 → only digit 0 shows 0x3F.
- Hex mode: D=0x00FA → with HEX_EN=1, digit 0=0x77 and digit 1=0x71. With HEX_EN=0, both show 0x00. Assert RST_N low mid-slot → SEG=0x00 and DIG_N=F immediately.
